// File: rtl/sine_channel_scheduler_pkg.sv
// Shared types for the multi-channel DDS scheduler: FSM states and the return-path tag.
package sine_channel_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  // Tag index is sized for the largest supported channel count so the type stays parameter-free.
  localparam int unsigned MAX_CH   = 8;
  localparam int unsigned CH_IDX_W = $clog2(MAX_CH);

  typedef struct packed {
    logic                valid;
    logic [CH_IDX_W-1:0] ch_idx;
  } tag_t;

endpackage

// File: rtl/sine_channel_scheduler_if.sv
// Config write bus and sine lookup port shared between the scheduler and its surroundings.
interface sine_channel_scheduler_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned PH_W   = 8,
  parameter int unsigned SMP_W  = 8
);
  logic                      cfg_we;
  logic [$clog2(NUM_CH)-1:0] cfg_ch;
  logic [ACC_W-1:0]          cfg_ftw;
  logic                      cfg_en;
  logic [PH_W-1:0]           lut_phase;
  logic [SMP_W-1:0]          lut_sample;

  modport master (
    output cfg_we, cfg_ch, cfg_ftw, cfg_en, lut_sample,
    input  lut_phase
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_ftw, cfg_en, lut_sample,
    output lut_phase
  );
endinterface

// File: rtl/sine_channel_scheduler_dds_phase_acc.sv
// One DDS channel: live FTW/enable, per-frame shadow copies and the phase accumulator.
module dds_phase_acc #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned PH_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             cfg_en,
  input  logic [ACC_W-1:0] cfg_ftw,
  input  logic             latch,
  input  logic             step,
  output logic [PH_W-1:0]  phase,
  output logic             active
);

  logic [ACC_W-1:0] ftw_q;
  logic [ACC_W-1:0] ftw_shadow_q;
  logic [ACC_W-1:0] acc_q;
  logic             en_q;
  logic             en_shadow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ftw_q        <= '0;
      ftw_shadow_q <= '0;
      acc_q        <= '0;
      en_q         <= 1'b0;
      en_shadow_q  <= 1'b0;
    end else begin
      if (sel) begin
        ftw_q <= cfg_ftw;
        en_q  <= cfg_en;
      end
      // Shadow samples the pre-write value when a write lands on the latch cycle.
      if (latch) begin
        ftw_shadow_q <= ftw_q;
        en_shadow_q  <= en_q;
      end
      if (sel && !cfg_en) begin
        acc_q <= '0;
      end else if (step && en_shadow_q) begin
        acc_q <= acc_q + ftw_shadow_q;
      end
    end
  end

  assign phase  = acc_q[ACC_W-1 -: PH_W];
  assign active = en_shadow_q;

endmodule

// File: rtl/sine_channel_scheduler.sv
// Time-multiplexes one registered sine lookup across NUM_CH DDS channels, one frame per tick.
module sine_channel_scheduler
  import sine_channel_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned PH_W    = 8,
  parameter int unsigned SMP_W   = 8,
  parameter int unsigned LUT_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    clr_overrun,
  sine_channel_scheduler_if.slave bus,
  output logic [NUM_CH*SMP_W-1:0] ch_sample,
  output logic [NUM_CH-1:0]       ch_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);
  localparam int unsigned CNT_W = $clog2(NUM_CH + LUT_LAT);

  state_t                         state_q;
  state_t                         state_d;
  logic [CNT_W-1:0]               cnt_q;
  logic [CNT_W-1:0]               cnt_d;
  logic                           accept;
  logic                           issuing;
  logic [IDX_W-1:0]               slot;
  tag_t                           tag_in;
  tag_t                           tag_q [LUT_LAT];
  tag_t                           tag_out;
  logic [NUM_CH-1:0]              active;
  logic [PH_W-1:0]                ch_phase [NUM_CH];
  logic [NUM_CH-1:0][SMP_W-1:0]   sample_q;

  assign slot = cnt_q[IDX_W-1:0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dds_phase_acc #(
      .ACC_W(ACC_W),
      .PH_W (PH_W)
    ) u_acc (
      .clk    (clk),
      .rst    (rst),
      .sel    (bus.cfg_we && (bus.cfg_ch == IDX_W'(i))),
      .cfg_en (bus.cfg_en),
      .cfg_ftw(bus.cfg_ftw),
      .latch  (accept),
      .step   (issuing && (slot == IDX_W'(i))),
      .phase  (ch_phase[i]),
      .active (active[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          accept  = 1'b1;
          state_d = ISSUE;
          cnt_d   = '0;
        end
      end
      ISSUE: begin
        if (cnt_q == CNT_W'(NUM_CH - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(LUT_LAT - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Disabled slots still burn a cycle so frame length never depends on configuration.
  always_comb begin
    issuing       = (state_q == ISSUE);
    busy          = (state_q != IDLE);
    tag_in.valid  = issuing && active[slot];
    tag_in.ch_idx = CH_IDX_W'(slot);
    bus.lut_phase = '0;
    if (tag_in.valid) begin
      bus.lut_phase = ch_phase[slot];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LUT_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_in;
      for (int unsigned i = 1; i < LUT_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out = tag_q[LUT_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= '0;
      ch_valid <= '0;
    end else begin
      ch_valid <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (tag_out.valid && (tag_out.ch_idx == CH_IDX_W'(i))) begin
          sample_q[i] <= bus.lut_sample;
          ch_valid[i] <= 1'b1;
        end
      end
    end
  end

  assign ch_sample = sample_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (tick && busy) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sine_channel_scheduler.sv
// Bench for sine_channel_scheduler: frame table plus hand sequences, samples scored via a queue.
module tb_sine_channel_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        clr_overrun = 1'b0;
  logic [31:0] ch_sample;
  logic [3:0]  ch_valid;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sine_channel_scheduler_if #(.NUM_CH(4), .ACC_W(16), .PH_W(8), .SMP_W(8)) bus ();

  sine_channel_scheduler #(
    .NUM_CH (4),
    .ACC_W  (16),
    .PH_W   (8),
    .SMP_W  (8),
    .LUT_LAT(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .clr_overrun(clr_overrun),
    .bus        (bus),
    .ch_sample  (ch_sample),
    .ch_valid   (ch_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] lutf(input logic [7:0] p);
    return {p[3:0], p[7:4]} ^ 8'h3C;
  endfunction

  // Two-stage registered lookup stand-in.
  logic [7:0] ph_d = '0;
  logic [7:0] smp_d = '0;
  always @(posedge clk) begin
    ph_d  <= bus.lut_phase;
    smp_d <= lutf(ph_d);
  end
  assign bus.lut_sample = smp_d;

  typedef struct {
    int         ch;
    logic [7:0] smp;
    int         at;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic            rst_before;
    logic            wr;
    logic [3:0][15:0] ftw;
    logic [3:0]      en;
    logic [3:0][7:0] ph;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    sb_t e;
    for (int i = 0; i < 4; i++) begin
      if (ch_valid[i] === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got pulse on ch%0d, expected none (cycle %0d)", i, cyc);
        end else begin
          e = sb.pop_front();
          check("valid_ch", i, e.ch);
          check("valid_cycle", cyc, e.at);
          check("valid_sample", ch_sample[i*8 +: 8], e.smp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input int ch, input logic [15:0] ftw, input logic en);
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = 2'(ch);
    bus.cfg_ftw = ftw;
    bus.cfg_en  = en;
  endtask

  task automatic cfg_write(input int ch, input logic [15:0] ftw, input logic en);
    step();
    drive_cfg(ch, ftw, en);
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    sb.delete();
    rst = 1'b0;
    @(negedge clk);
    check("rst_phase", bus.lut_phase, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_valid", ch_valid, 4'h0);
    check("rst_sample", ch_sample, 32'h0);
  endtask

  // wslot: -1 no write, -2 write on the tick cycle, 0..3 write during that issue slot.
  task automatic tick_frame(input logic [3:0][7:0] ph, input logic [3:0] en, input int wslot,
                            input int wch, input logic [15:0] wftw, input logic wen);
    int n;
    step();
    tick = 1'b1;
    n = cyc;
    if (wslot == -2) drive_cfg(wch, wftw, wen);
    for (int k = 0; k < 4; k++) begin
      if (en[k]) sb.push_back('{ch: k, smp: lutf(ph[k]), at: n + 4 + k});
    end
    step();
    tick = 1'b0;
    bus.cfg_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == wslot) drive_cfg(wch, wftw, wen);
      @(negedge clk);
      check($sformatf("phase_slot%0d", k), bus.lut_phase, ph[k]);
      check("busy_issue", busy, 1'b1);
      step();
      bus.cfg_we = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      check("phase_drain", bus.lut_phase, 8'h00);
      check("busy_drain", busy, 1'b1);
      step();
    end
    @(negedge clk);
    check("busy_end", busy, 1'b0);
    step();
  endtask

  function automatic vec_t mkv(input logic rb, input logic wr,
                               input logic [15:0] f3, f2, f1, f0, input logic [3:0] en,
                               input logic [7:0] p3, p2, p1, p0);
    vec_t v;
    v.rst_before = rb;
    v.wr         = wr;
    v.ftw        = {f3, f2, f1, f0};
    v.en         = en;
    v.ph         = {p3, p2, p1, p0};
    return v;
  endfunction

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    vec_t tv[13];
    sb_t  keep[$];
    int   n;

    bus.cfg_we  = 1'b0;
    bus.cfg_ch  = '0;
    bus.cfg_ftw = '0;
    bus.cfg_en  = 1'b0;

    tv[0]  = mkv(1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h4000, 4'b0001, 8'h00, 8'h00, 8'h00, 8'h00);
    tv[1]  = mkv(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 8'h00, 8'h00, 8'h00, 8'h40);
    tv[2]  = mkv(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 8'h00, 8'h00, 8'h00, 8'h80);
    tv[3]  = mkv(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 8'h00, 8'h00, 8'h00, 8'hC0);
    tv[4]  = mkv(1, 1, 16'h0400, 16'h0300, 16'h0200, 16'h0100, 4'b1111, 8'h00, 8'h00, 8'h00, 8'h00);
    tv[5]  = mkv(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b1111, 8'h04, 8'h03, 8'h02, 8'h01);
    tv[6]  = mkv(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b1111, 8'h08, 8'h06, 8'h04, 8'h02);
    tv[7]  = mkv(1, 1, 16'h0000, 16'h0000, 16'hFFF0, 16'h0000, 4'b0010, 8'h00, 8'h00, 8'h00, 8'h00);
    tv[8]  = mkv(0, 1, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 4'b0010, 8'h00, 8'h00, 8'hFF, 8'h00);
    tv[9]  = mkv(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0010, 8'h00, 8'h00, 8'hFF, 8'h00);
    tv[10] = mkv(0, 1, 16'h0000, 16'h0000, 16'hFF00, 16'h0000, 4'b0010, 8'h00, 8'h00, 8'hFF, 8'h00);
    tv[11] = mkv(0, 1, 16'h0000, 16'h0000, 16'h0200, 16'h0000, 4'b0010, 8'h00, 8'h00, 8'hFE, 8'h00);
    tv[12] = mkv(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0010, 8'h00, 8'h00, 8'h00, 8'h00);

    for (int r = 0; r < 13; r++) begin
      if (tv[r].rst_before) do_reset();
      if (tv[r].wr) begin
        for (int c = 0; c < 4; c++) cfg_write(c, tv[r].ftw[c], tv[r].en[c]);
      end
      tick_frame(tv[r].ph, tv[r].en, -1, 0, 16'h0, 1'b0);
      step();
    end

    // Overrun: tick on the 3rd busy cycle and in the last drain cycle are both dropped.
    do_reset();
    cfg_write(0, 16'h1000, 1'b1);
    step();
    tick = 1'b1;
    n = cyc;
    sb.push_back('{ch: 0, smp: lutf(8'h00), at: n + 4});
    step(); tick = 1'b0;
    step();
    step(); tick = 1'b1;
    step(); tick = 1'b0;
    @(negedge clk);
    check("ovr_set", overrun, 1'b1);
    check("ovr_busy", busy, 1'b1);
    step();
    step(); tick = 1'b1;
    @(negedge clk);
    check("last_drain_busy", busy, 1'b1);
    step(); tick = 1'b0;
    @(negedge clk);
    check("no_new_frame_busy", busy, 1'b0);
    check("no_new_frame_phase", bus.lut_phase, 8'h00);
    check("ovr_sticky", overrun, 1'b1);
    step();
    tick = 1'b1;
    n = cyc;
    sb.push_back('{ch: 0, smp: lutf(8'h10), at: n + 4});
    step(); tick = 1'b0;
    @(negedge clk);
    check("frame2_phase", bus.lut_phase, 8'h10);
    step(); tick = 1'b1; clr_overrun = 1'b1;
    step(); tick = 1'b0; clr_overrun = 1'b0;
    @(negedge clk);
    check("ovr_set_wins", overrun, 1'b1);
    step(); clr_overrun = 1'b1;
    step(); clr_overrun = 1'b0;
    @(negedge clk);
    check("ovr_cleared", overrun, 1'b0);
    repeat (4) step();

    // Shadow and disable/enable behaviour on ch2.
    do_reset();
    cfg_write(2, 16'h1000, 1'b1);
    tick_frame({8'h00, 8'h00, 8'h00, 8'h00}, 4'b0100, -1, 0, 16'h0, 1'b0);
    tick_frame({8'h00, 8'h10, 8'h00, 8'h00}, 4'b0100, -2, 2, 16'h3000, 1'b1);
    tick_frame({8'h00, 8'h20, 8'h00, 8'h00}, 4'b0100, -1, 0, 16'h0, 1'b0);
    tick_frame({8'h00, 8'h50, 8'h00, 8'h00}, 4'b0100, -1, 0, 16'h0, 1'b0);
    tick_frame({8'h00, 8'h80, 8'h00, 8'h00}, 4'b0100, 2, 2, 16'h3000, 1'b0);
    tick_frame({8'h00, 8'h00, 8'h00, 8'h00}, 4'b0000, -1, 0, 16'h0, 1'b0);
    check("hold_ch2", ch_sample[23:16], lutf(8'h80));
    cfg_write(2, 16'h3000, 1'b1);
    tick_frame({8'h00, 8'h00, 8'h00, 8'h00}, 4'b0100, -1, 0, 16'h0, 1'b0);
    tick_frame({8'h00, 8'h30, 8'h00, 8'h00}, 4'b0100, -1, 0, 16'h0, 1'b0);

    // Reset in the first drain cycle cancels the two outstanding samples.
    do_reset();
    for (int c = 0; c < 4; c++) cfg_write(c, 16'(16'h1000 * (c + 1)), 1'b1);
    step();
    tick = 1'b1;
    n = cyc;
    for (int k = 0; k < 4; k++) sb.push_back('{ch: k, smp: lutf(8'h00), at: n + 4 + k});
    step(); tick = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rstseq_phase", bus.lut_phase, 8'h00);
      step();
    end
    rst = 1'b1;
    keep.delete();
    foreach (sb[i]) if (sb[i].at <= cyc) keep.push_back(sb[i]);
    sb = keep;
    @(negedge clk);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rstseq_busy", busy, 1'b0);
    check("rstseq_valid", ch_valid, 4'h0);
    check("rstseq_sample", ch_sample, 32'h0);
    repeat (3) begin
      step();
      @(negedge clk);
      check("rstseq_quiet", ch_valid, 4'h0);
    end
    for (int c = 0; c < 4; c++) cfg_write(c, 16'(16'h1000 * (c + 1)), 1'b1);
    tick_frame({8'h00, 8'h00, 8'h00, 8'h00}, 4'b1111, -1, 0, 16'h0, 1'b0);
    tick_frame({8'h40, 8'h30, 8'h20, 8'h10}, 4'b1111, -1, 0, 16'h0, 1'b0);

    repeat (3) step();
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sine_channel_scheduler.md
Name: sine_channel_scheduler

Overview:
Time-multiplexes the single registered sine lookup datapath (8-bit phase in, 8-bit sample out, fixed pipeline latency) across NUM_CH independent DDS channels. Each channel has its own phase accumulator and frequency tuning word (FTW). On every sample tick the scheduler runs one frame: it issues one phase per channel, collects the returned samples, and holds them per channel. It sits between the top-level config/IO logic and the sine lookup pipeline.

Parameters:
NUM_CH, 4, number of channels (power of 2, 2..8)
ACC_W, 16, phase accumulator / FTW width
PH_W, 8, lookup phase width (accumulator MSBs)
SMP_W, 8, lookup sample width
LUT_LAT, 2, cycles from lut_phase driven to lut_sample valid (phase reg + sample reg)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
tick  in  1  frame start strobe
cfg_we  in  1  config write strobe
cfg_ch  in  $clog2(NUM_CH)  channel addressed by write
cfg_ftw  in  ACC_W  tuning word
cfg_en  in  1  channel enable
clr_overrun  in  1  clears overrun flag
lut_phase  out  PH_W  phase to sine lookup
lut_sample  in  SMP_W  sample returned LUT_LAT cycles after phase
ch_sample  out  NUM_CH*SMP_W  held sample per channel, ch0 in LSBs
ch_valid  out  NUM_CH  one-cycle pulse when that channel's sample updates
busy  out  1  frame in progress
overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: all accumulators, FTWs, enables, ch_sample, ch_valid, lut_phase, overrun = 0; state IDLE; busy = 0.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: when tick=1, go to ISSUE and set busy=1 in the following cycle. The per-channel FTW/enable shadow copies are latched in that same cycle.
- ISSUE: lasts exactly NUM_CH cycles with channel index k = 0..NUM_CH-1.
  - Enabled channel: lut_phase = acc[k][ACC_W-1 -: PH_W], and acc[k] <= acc[k] + ftw_shadow[k], wrapping mod 2^ACC_W.
  - Disabled channel: lut_phase = 0, nothing tagged, and the slot is still consumed so frame timing is fixed.
  - Then go to DRAIN.
- DRAIN: LUT_LAT cycles, then IDLE with busy=0. Frame length is always NUM_CH+LUT_LAT cycles.
- Return path: a tag shift register of depth LUT_LAT carries {valid, k}. When a valid tag emerges, ch_sample[k] <= lut_sample and ch_valid[k] pulses for 1 cycle.
- Sample k is valid in ch_sample at cycle (issue cycle of k) + LUT_LAT + 1.
- lut_phase is 0 in IDLE and DRAIN.
- tick while busy: the tick is dropped and overrun <= 1. tick in the last DRAIN cycle is also dropped.
- Overrun set and clear: clr_overrun clears overrun. If both happen in the same cycle, set wins.
- Config write: updates the live FTW/enable registers immediately.
  - The running frame uses the shadows, so a write takes effect from the next frame.
  - If cfg_we and an accepted tick occur in the same cycle, the shadow takes the pre-write value.
- Disable/enable: a write with cfg_en=0 clears acc[cfg_ch] to 0 at the write cycle; ch_sample[cfg_ch] holds its last value. Re-enabling starts from phase 0.
- Accumulator hazard: a write to a channel's acc-clear while ISSUE is on that same channel is resolved by the clear winning.
- Reset mid-frame: pending tags are discarded, no ch_valid pulses, and all state returns to reset values.

Decomposition:
- Shared package: state enum (IDLE/ISSUE/DRAIN), CH_IDX_W = $clog2(NUM_CH), and the tag struct {valid, ch_idx}.
- Sub-module dds_phase_acc holds one channel's FTW, enable, shadow and accumulator (clear, step, msb phase out). Instantiate it NUM_CH times.
- The scheduler holds the FSM, the tag pipeline and the sample registers.

Test Plan:
- Reset, then ch0 ftw=0x4000 enabled, others disabled; 4 ticks spaced 10 cycles -> ch0 issues phases 0x00,0x40,0x80,0xC0; ch_valid[0] pulses once per frame at issue+3; ch_valid[3:1] never pulse.
- All 4 channels, ftw=0x0100,0x0200,0x0300,0x0400; single tick -> lut_phase=0 on 4 consecutive cycles; busy high for 6 cycles; ch_valid pulses 0,1,2,3 on consecutive cycles. Second tick -> phases 0x01,0x02,0x03,0x04.
- Wrap: ch1 ftw=0xFFFF and acc preloaded via 1 frame of ftw=0xFFF0 -> accumulator wraps mod 2^16 without glitch; phase MSBs follow 0xFF then 0xFF/0xFE sequence exactly per model.
- tick asserted on the 3rd busy cycle -> no new frame; overrun=1 stays set. clr_overrun plus a second overrun tick in the same cycle -> overrun remains 1.
- cfg_we to ch2 (ftw change) in the same cycle as an accepted tick -> the current frame uses the old ftw and the next frame uses the new one. A cfg_en=0 write mid-frame -> acc2=0 and ch_sample[2] holds.
- rst asserted during DRAIN -> ch_valid stays 0, busy=0 next cycle, ch_sample all 0, and the next tick frame issues phase 0 on all channels.
